// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation controller input front end.
// Channel indices are positions in the conditioner's packed input vectors.
package irrigation_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      REPEATING,
      HELD_AT_START
   } button_state_t;

   localparam int SYNC_STAGES = 2;
   localparam int NUM_CH      = 8;

   localparam int CH_LOW_WATER  = 0;
   localparam int CH_MID_WATER  = 1;
   localparam int CH_HIGH_WATER = 2;
   localparam int CH_EARTH_HUM  = 3;
   localparam int CH_AIR_HUM    = 4;
   localparam int CH_LOW_TEMP   = 5;
   localparam int CH_PULSE_2    = 6;
   localparam int CH_PULSE_3    = 7;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchronizer, mismatch counter and clean level flop.
// Active-low inputs are inverted after synchronization (1 = asserted inside).
module debounce_channel
   import irrigation_pkg::*;
#(
   parameter int STABLE_COUNT = 16,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   input  logic startup_bypass,
   output logic clean
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
   assign clean  = clean_q;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
      clean_d = clean_q;
      cnt_d   = '0;
      if (startup_bypass) begin
         clean_d = synced;
      end else if (synced != clean_q) begin
         // Toggle on the STABLE_COUNT-th consecutive mismatch
         if (cnt_q == 8'(STABLE_COUNT - 1)) begin
            clean_d = ~clean_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= {SYNC_STAGES{ACTIVE_LOW}};
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

endmodule

// File: rtl/sensor_input_conditioner.sv
// Input front end: debounced sensor levels, button ticks with auto-repeat,
// water-probe conflict flag and a startup valid flag.
module sensor_input_conditioner
   import irrigation_pkg::*;
#(
   parameter int STABLE_COUNT  = 16,
   parameter int HOLD_CYCLES   = 1024,
   parameter int REPEAT_CYCLES = 256
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_low_water_level,
   input  logic raw_mid_water_level,
   input  logic raw_high_water_level,
   input  logic raw_earth_humidity,
   input  logic raw_air_humidity,
   input  logic raw_low_temperature,
   input  logic raw_pulse_2_n,
   input  logic raw_pulse_3_n,
   output logic low_water_level,
   output logic mid_water_level,
   output logic high_water_level,
   output logic earth_humidity,
   output logic air_humidity,
   output logic low_temperature,
   output logic pulse_2,
   output logic pulse_3,
   output logic conflicting_values,
   output logic inputs_valid
);

   localparam int BTN_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                            HOLD_CYCLES : REPEAT_CYCLES;
   localparam int BTN_CW  = $clog2(BTN_MAX);

   logic [NUM_CH-1:0] raw_vec, clean_vec;

   logic [8:0]  start_q, start_d;
   logic        valid_q, valid_d;
   logic        conflict_q, conflict_d;

   button_state_t     state_q [2];
   button_state_t     state_d [2];
   logic [BTN_CW-1:0] cnt_q   [2];
   logic [BTN_CW-1:0] cnt_d   [2];
   logic [1:0]        tick_q, tick_d;

   assign raw_vec[CH_LOW_WATER]  = raw_low_water_level;
   assign raw_vec[CH_MID_WATER]  = raw_mid_water_level;
   assign raw_vec[CH_HIGH_WATER] = raw_high_water_level;
   assign raw_vec[CH_EARTH_HUM]  = raw_earth_humidity;
   assign raw_vec[CH_AIR_HUM]    = raw_air_humidity;
   assign raw_vec[CH_LOW_TEMP]   = raw_low_temperature;
   assign raw_vec[CH_PULSE_2]    = raw_pulse_2_n;
   assign raw_vec[CH_PULSE_3]    = raw_pulse_3_n;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_COUNT (STABLE_COUNT),
         .ACTIVE_LOW   (i >= CH_PULSE_2)
      ) u_db (
         .clock          (clock),
         .reset          (reset),
         .raw            (raw_vec[i]),
         .startup_bypass (~valid_q),
         .clean          (clean_vec[i])
      );
   end

   always_comb begin
      start_d    = valid_q ? start_q : start_q + 9'd1;
      valid_d    = valid_q | (start_q == 9'(STABLE_COUNT + 1));
      conflict_d = valid_q &
                   ((clean_vec[CH_HIGH_WATER] & ~clean_vec[CH_MID_WATER]) |
                    (clean_vec[CH_MID_WATER]  & ~clean_vec[CH_LOW_WATER]));
   end

   always_comb begin
      tick_d = '0;
      for (int b = 0; b < 2; b++) begin
         state_d[b] = state_q[b];
         cnt_d[b]   = cnt_q[b];
         // Presses seen during settling are parked until released
         if (!valid_q) begin
            state_d[b] = clean_vec[CH_PULSE_2 + b] ? HELD_AT_START : IDLE;
            cnt_d[b]   = '0;
         end else begin
            unique case (state_q[b])
               IDLE: begin
                  if (clean_vec[CH_PULSE_2 + b]) begin
                     state_d[b] = PRESSED;
                     tick_d[b]  = 1'b1;
                     cnt_d[b]   = '0;
                  end
               end
               PRESSED: begin
                  if (!clean_vec[CH_PULSE_2 + b]) begin
                     state_d[b] = IDLE;
                  end else if (cnt_q[b] == BTN_CW'(HOLD_CYCLES - 1)) begin
                     state_d[b] = REPEATING;
                     tick_d[b]  = 1'b1;
                     cnt_d[b]   = '0;
                  end else begin
                     cnt_d[b] = cnt_q[b] + 1'b1;
                  end
               end
               REPEATING: begin
                  if (!clean_vec[CH_PULSE_2 + b]) begin
                     state_d[b] = IDLE;
                  end else if (cnt_q[b] == BTN_CW'(REPEAT_CYCLES - 1)) begin
                     tick_d[b] = 1'b1;
                     cnt_d[b]  = '0;
                  end else begin
                     cnt_d[b] = cnt_q[b] + 1'b1;
                  end
               end
               HELD_AT_START: begin
                  if (!clean_vec[CH_PULSE_2 + b]) begin
                     state_d[b] = IDLE;
                  end
               end
               default: state_d[b] = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         start_q    <= '0;
         valid_q    <= 1'b0;
         conflict_q <= 1'b0;
         tick_q     <= '0;
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= IDLE;
            cnt_q[b]   <= '0;
         end
      end else begin
         start_q    <= start_d;
         valid_q    <= valid_d;
         conflict_q <= conflict_d;
         tick_q     <= tick_d;
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
         end
      end
   end

   assign low_water_level    = clean_vec[CH_LOW_WATER];
   assign mid_water_level    = clean_vec[CH_MID_WATER];
   assign high_water_level   = clean_vec[CH_HIGH_WATER];
   assign earth_humidity     = clean_vec[CH_EARTH_HUM];
   assign air_humidity       = clean_vec[CH_AIR_HUM];
   assign low_temperature    = clean_vec[CH_LOW_TEMP];
   assign pulse_2            = tick_q[0];
   assign pulse_3            = tick_q[1];
   assign conflicting_values = conflict_q;
   assign inputs_valid       = valid_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: per-cycle behavioural model compare
// plus directed scenarios with hand-computed cycle expectations.
module tb_sensor_input_conditioner;

   localparam int SC   = 16;
   localparam int HOLD = 1024;
   localparam int REP  = 256;
   localparam int HMAX = 16384;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic raw_low_water_level  = 1'b0;
   logic raw_mid_water_level  = 1'b0;
   logic raw_high_water_level = 1'b0;
   logic raw_earth_humidity   = 1'b0;
   logic raw_air_humidity     = 1'b0;
   logic raw_low_temperature  = 1'b0;
   logic raw_pulse_2_n        = 1'b1;
   logic raw_pulse_3_n        = 1'b1;
   logic low_water_level, mid_water_level, high_water_level;
   logic earth_humidity, air_humidity, low_temperature;
   logic pulse_2, pulse_3, conflicting_values, inputs_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clock = ~clock;

   sensor_input_conditioner #(
      .STABLE_COUNT  (SC),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .raw_low_water_level  (raw_low_water_level),
      .raw_mid_water_level  (raw_mid_water_level),
      .raw_high_water_level (raw_high_water_level),
      .raw_earth_humidity   (raw_earth_humidity),
      .raw_air_humidity     (raw_air_humidity),
      .raw_low_temperature  (raw_low_temperature),
      .raw_pulse_2_n        (raw_pulse_2_n),
      .raw_pulse_3_n        (raw_pulse_3_n),
      .low_water_level      (low_water_level),
      .mid_water_level      (mid_water_level),
      .high_water_level     (high_water_level),
      .earth_humidity       (earth_humidity),
      .air_humidity         (air_humidity),
      .low_temperature      (low_temperature),
      .pulse_2              (pulse_2),
      .pulse_3              (pulse_3),
      .conflicting_values   (conflicting_values),
      .inputs_valid         (inputs_valid)
   );

   always @(posedge clock) cyc++;

   // Model: raw history, levels by run-length rule, ticks by time since press
   bit hist [8][HMAX];
   int n;
   bit mc [8];
   bit pc [8];
   int last_chg [8];
   bit m_valid, v_prev, m_conf, ok;
   bit m_tick [2];
   int mode [2];
   int pstart [2];
   int d;

   function automatic bit synced(int ch, int k);
      if (k - 2 < 1) return 1'b0;
      return hist[ch][k-2];
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         n = 0;
         m_valid = 0;
         m_conf = 0;
         for (int c = 0; c < 8; c++) begin
            mc[c] = 0;
            last_chg[c] = 0;
         end
         for (int b = 0; b < 2; b++) begin
            m_tick[b] = 0;
            mode[b] = 0;
            pstart[b] = 0;
         end
      end else begin
         n++;
         if (n < HMAX) begin
            hist[0][n] = raw_low_water_level;
            hist[1][n] = raw_mid_water_level;
            hist[2][n] = raw_high_water_level;
            hist[3][n] = raw_earth_humidity;
            hist[4][n] = raw_air_humidity;
            hist[5][n] = raw_low_temperature;
            hist[6][n] = ~raw_pulse_2_n;
            hist[7][n] = ~raw_pulse_3_n;
         end
         pc = mc;
         v_prev = m_valid;
         for (int c = 0; c < 8; c++) begin
            if (n <= SC + 2) begin
               mc[c] = synced(c, n);
               last_chg[c] = n;
            end else begin
               ok = 1;
               for (int k = n - SC + 1; k <= n; k++)
                  if (k <= last_chg[c] || synced(c, k) == pc[c]) ok = 0;
               if (ok) begin
                  mc[c] = ~pc[c];
                  last_chg[c] = n;
               end
            end
         end
         m_valid = (n >= SC + 2);
         m_conf = v_prev & ((pc[2] & ~pc[1]) | (pc[1] & ~pc[0]));
         for (int b = 0; b < 2; b++) begin
            m_tick[b] = 0;
            if (!v_prev) begin
               mode[b] = pc[6+b] ? 2 : 0;
            end else if (mode[b] == 0) begin
               if (pc[6+b]) begin
                  mode[b] = 1;
                  pstart[b] = n;
                  m_tick[b] = 1;
               end
            end else if (mode[b] == 1) begin
               if (!pc[6+b]) begin
                  mode[b] = 0;
               end else begin
                  d = n - pstart[b];
                  if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0))
                     m_tick[b] = 1;
               end
            end else begin
               if (!pc[6+b]) mode[b] = 0;
            end
         end
      end
   end

   logic [9:0] act_vec, exp_vec;
   assign act_vec = {low_water_level, mid_water_level, high_water_level,
                     earth_humidity, air_humidity, low_temperature,
                     pulse_2, pulse_3, conflicting_values, inputs_valid};

   always @(negedge clock) begin
      exp_vec = reset ? 10'd0 :
                {mc[0], mc[1], mc[2], mc[3], mc[4], mc[5],
                 m_tick[0], m_tick[1], m_conf, m_valid};
      checks++;
      if (act_vec !== exp_vec) begin
         errors++;
         $display("FAIL cycle_compare cyc=%0d actual=%b required=%b",
                  cyc, act_vec, exp_vec);
      end
   end

   int t2q [$];
   int t3q [$];
   always @(negedge clock) begin
      if (!reset && pulse_2) t2q.push_back(cyc);
      if (!reset && pulse_3) t3q.push_back(cyc);
   end

   task automatic check(string name, int act, int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic edges(int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   task automatic look(int k);
      repeat (k) @(posedge clock);
      @(negedge clock);
   endtask

   int d0;
   int exp_off [5] = '{19, 1043, 1299, 1555, 1811};

   initial begin
      // Startup: valid after the 18th edge following reset release
      edges(3);
      reset = 1'b0;
      look(17);
      check("valid_before_18", inputs_valid, 0);
      check("levels_startup", act_vec, 0);
      look(1);
      check("valid_at_18", inputs_valid, 1);
      check("conflict_idle", conflicting_values, 0);

      // Mid probe: 18-cycle latency, conflict one cycle later
      edges(1);
      raw_mid_water_level = 1'b1;
      look(17);
      check("mid_before_18", mid_water_level, 0);
      look(1);
      check("mid_at_18", mid_water_level, 1);
      check("conflict_lag", conflicting_values, 0);
      look(1);
      check("conflict_set", conflicting_values, 1);
      edges(1);
      raw_low_water_level  = 1'b1;
      raw_high_water_level = 1'b1;
      raw_air_humidity     = 1'b1;
      look(25);
      check("conflict_clear", conflicting_values, 0);
      check("high_level", high_water_level, 1);

      // Glitches: 10 and 15 cycles filtered, 16 cycles passes
      edges(1);
      raw_earth_humidity = 1'b1;
      edges(10);
      raw_earth_humidity = 1'b0;
      look(30);
      check("glitch_10", earth_humidity, 0);
      edges(1);
      raw_earth_humidity = 1'b1;
      edges(15);
      raw_earth_humidity = 1'b0;
      look(30);
      check("glitch_15", earth_humidity, 0);
      edges(1);
      raw_earth_humidity = 1'b1;
      edges(16);
      raw_earth_humidity = 1'b0;
      look(2);
      check("pulse_16", earth_humidity, 1);
      edges(40);

      // Hold button 2 for 2000 cycles: press tick plus four repeats
      t2q.delete();
      edges(1);
      raw_pulse_2_n = 1'b0;
      d0 = cyc;
      edges(2000);
      raw_pulse_2_n = 1'b1;
      look(40);
      check("b2_tick_count", t2q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < t2q.size())
            check($sformatf("b2_tick_%0d", i), t2q[i] - d0, exp_off[i]);

      // Button 3 held through reset release: parked, then one tick
      edges(1);
      reset = 1'b1;
      raw_pulse_3_n = 1'b0;
      edges(3);
      reset = 1'b0;
      t3q.delete();
      look(100);
      check("b3_held_ticks", t3q.size(), 0);
      edges(1);
      raw_pulse_3_n = 1'b1;
      edges(40);
      raw_pulse_3_n = 1'b0;
      look(40);
      check("b3_after_release", t3q.size(), 1);
      edges(1);
      raw_pulse_3_n = 1'b1;
      edges(40);

      // Both buttons together tick on the same cycle
      t2q.delete();
      t3q.delete();
      raw_pulse_2_n = 1'b0;
      raw_pulse_3_n = 1'b0;
      look(30);
      check("both_b2", t2q.size(), 1);
      check("both_b3", t3q.size(), 1);
      if (t2q.size() == 1 && t3q.size() == 1)
         check("both_same_cycle", t2q[0], t3q[0]);
      edges(1);
      raw_pulse_2_n = 1'b1;
      raw_pulse_3_n = 1'b1;
      edges(40);

      // Reset while repeating with mid high
      t2q.delete();
      raw_pulse_2_n = 1'b0;
      edges(1100);
      check("rep_ticks_before_reset", t2q.size(), 2);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", act_vec, 0);
      raw_pulse_2_n = 1'b1;
      edges(3);
      reset = 1'b0;
      t2q.delete();
      look(60);
      check("no_tick_after_reset", t2q.size(), 0);
      check("mid_after_reset", mid_water_level, 1);
      check("valid_after_reset", inputs_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
